// File: rtl/palin_pkg.sv
// Shared definitions for the palindrome path: FSM states, default width,
// and the bit-reverse function also used by the downstream checker.
package palin_pkg;

    localparam int PALIN_N = 8;
    localparam int HALF    = PALIN_N / 2;
    localparam int MAXW    = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAXW-1:0] bit_rev(input logic [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_mirror.sv
// Combinational mirror: an N/2-bit seed becomes the N-bit palindrome
// {reverse(seed), seed}.
module bit_mirror #(
    parameter int N = 8
) (
    input  logic [N/2-1:0] seed,
    output logic [N-1:0]   word
);

    for (genvar i = 0; i < N/2; i++) begin : g_bit
        assign word[i]       = seed[i];
        assign word[N-1-i]   = seed[i];
    end

endmodule

// File: rtl/palin_gen.sv
// Serial palindrome word generator: seed in, mirrored word out LSB first.
// Optional self-checker enabled by PALIN_GEN_SELFCHK_EN (adds chk_err).
module palin_gen
    import palin_pkg::*;
#(
    parameter int N = PALIN_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           seed_valid,
    output logic           seed_ready,
    input  logic [N/2-1:0] seed,
    output logic           ser_valid,
    input  logic           ser_ready,
    output logic           ser_out,
    output logic           ser_last,
    output logic [N-1:0]   word_out,
    output logic           done
`ifdef PALIN_GEN_SELFCHK_EN
    ,
    output logic           chk_err
`endif
);

    localparam int CW = $clog2(N);

    state_t          state, state_nxt;
    logic [N-1:0]    shreg;
    logic [N-1:0]    mirror_word;
    logic [CW-1:0]   cnt;
    logic            load;
    logic            beat;

    bit_mirror #(.N(N)) u_mirror (
        .seed (seed),
        .word (mirror_word)
    );

    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[0];
                ser_last  = (cnt == CW'(N-1));
                if (ser_ready) begin
                    beat = 1'b1;
                    if (ser_last) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            word_out <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shreg    <= mirror_word;
                word_out <= mirror_word;
                cnt      <= '0;
            end else if (beat) begin
                shreg <= {1'b0, shreg[N-1:1]};
                // Hold on the last beat so the counter never wraps.
                if (!ser_last) cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef PALIN_GEN_SELFCHK_EN
    logic [N-1:0] chk_word;
    logic [N-1:0] chk_ref;
    logic [N-1:0] rx;
    logic         chk_pend;

    bit_mirror #(.N(N)) u_chk_mirror (
        .seed (seed),
        .word (chk_word)
    );

    // The word is checked the cycle after load, once word_out holds it;
    // the reassembled stream is checked while in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err  <= 1'b0;
            chk_pend <= 1'b0;
            chk_ref  <= '0;
            rx       <= '0;
        end else begin
            chk_pend <= load;
            if (load) begin
                chk_ref <= chk_word;
                rx      <= '0;
            end
            if (beat) rx <= {ser_out, rx[N-1:1]};
            if (chk_pend && ((word_out != chk_ref) ||
                             (word_out != N'(bit_rev(MAXW'(word_out), N)))))
                chk_err <= 1'b1;
            if (done && (rx != word_out)) chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_palin_gen.sv
// Directed bench for palin_gen (N=8); checks the self-check path when
// PALIN_GEN_SELFCHK_EN is defined.
module tb_palin_gen;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_valid;
    logic         seed_ready;
    logic [3:0]   seed;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_out;
    logic         ser_last;
    logic [7:0]   word_out;
    logic         done;
`ifdef PALIN_GEN_SELFCHK_EN
    logic         chk_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    palin_gen #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed       (seed),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_out    (ser_out),
        .ser_last   (ser_last),
        .word_out   (word_out),
        .done       (done)
`ifdef PALIN_GEN_SELFCHK_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    always #5 clk = ~clk;

    // Presents a seed for one accept edge; returns at the negedge where beat 0 is visible.
    task automatic send_seed(input logic [3:0] s);
        @(negedge clk);
        seed       = s;
        seed_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seed_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; seed_valid = 1'b0; seed = '0; ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (seed_ready !== 1'b1) begin n_err++; $display("FAIL reset_seed_ready got %b want 1", seed_ready); end
        n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid got %b want 0", ser_valid); end
        n_cmp++; if (ser_out !== 1'b0 || ser_last !== 1'b0) begin n_err++; $display("FAIL reset_ser got out=%b last=%b want 0/0", ser_out, ser_last); end
        n_cmp++; if (word_out !== 8'h00) begin n_err++; $display("FAIL reset_word_out got %h want 00", word_out); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] exp;
        exp = 8'hC3;  // seed 0011 -> 1100_0011
        ser_ready = 1'b1;
        send_seed(4'b0011);
        n_cmp++; if (word_out !== exp) begin n_err++; $display("FAIL basic_word got %h want %h", word_out, exp); end
        for (int b = 0; b < 8; b++) begin
            n_cmp++; if (ser_valid !== 1'b1 || ser_out !== exp[b] || ser_last !== (b == 7))
                begin n_err++; $display("FAIL basic_beat%0d got v=%b o=%b l=%b want 1/%b/%b", b, ser_valid, ser_out, ser_last, exp[b], b == 7); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1 || ser_valid !== 1'b0 || seed_ready !== 1'b0)
            begin n_err++; $display("FAIL basic_done got d=%b v=%b r=%b want 1/0/0", done, ser_valid, seed_ready); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || seed_ready !== 1'b1)
            begin n_err++; $display("FAIL basic_idle got d=%b r=%b want 0/1", done, seed_ready); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp;
        int beat;
        exp  = 8'h5A;  // seed 1010 -> 0101_1010
        beat = 0;
        send_seed(4'b1010);
        n_cmp++; if (word_out !== exp) begin n_err++; $display("FAIL bp_word got %h want %h", word_out, exp); end
        for (int cyc = 0; cyc < 13; cyc++) begin
            ser_ready = !(cyc >= 3 && cyc < 8);
            n_cmp++; if (ser_valid !== 1'b1 || ser_out !== exp[beat] || ser_last !== (beat == 7))
                begin n_err++; $display("FAIL bp_cyc%0d got v=%b o=%b l=%b want 1/%b/%b", cyc, ser_valid, ser_out, ser_last, exp[beat], beat == 7); end
            if (ser_ready) beat++;
            @(negedge clk);
        end
        ser_ready = 1'b1;
        n_cmp++; if (done !== 1'b1 || ser_valid !== 1'b0) begin n_err++; $display("FAIL bp_done got d=%b v=%b want 1/0", done, ser_valid); end
        @(negedge clk);
    endtask

    task automatic test_ignore_seed;
        logic [7:0] exp;
        exp = 8'h66;  // seed 0110 mirrors to itself
        send_seed(4'b0110);
        for (int b = 0; b < 8; b++) begin
            seed_valid = (b >= 1 && b <= 6);
            seed       = 4'hF;
            n_cmp++; if (seed_ready !== 1'b0 || word_out !== exp || ser_out !== exp[b])
                begin n_err++; $display("FAIL ign_beat%0d got r=%b w=%h o=%b want 0/%h/%b", b, seed_ready, word_out, ser_out, exp, exp[b]); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done got %b want 1", done); end
        @(negedge clk);
        n_cmp++; if (word_out !== exp || seed_ready !== 1'b1) begin n_err++; $display("FAIL ign_after got w=%h r=%b want %h/1", word_out, seed_ready, exp); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp;
        send_seed(4'b1100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (ser_valid !== 1'b0 || seed_ready !== 1'b1 || ser_out !== 1'b0 || ser_last !== 1'b0 || word_out !== 8'h00 || done !== 1'b0)
            begin n_err++; $display("FAIL rstmid_outs got v=%b r=%b o=%b l=%b w=%h d=%b want 0/1/0/0/00/0", ser_valid, seed_ready, ser_out, ser_last, word_out, done); end
        rst_n = 1'b1;
        exp = 8'h81;
        send_seed(4'b0001);
        n_cmp++; if (word_out !== exp) begin n_err++; $display("FAIL rstmid_word got %h want %h", word_out, exp); end
        for (int b = 0; b < 8; b++) begin
            n_cmp++; if (ser_valid !== 1'b1 || ser_out !== exp[b] || ser_last !== (b == 7))
                begin n_err++; $display("FAIL rstmid_beat%0d got v=%b o=%b l=%b want 1/%b/%b", b, ser_valid, ser_out, ser_last, exp[b], b == 7); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        seed = 4'b0011; seed_valid = 1'b1; ser_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && second < 0; cyc++) begin
            if (seed_ready) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            @(negedge clk);
        end
        seed_valid = 1'b0;
        n_cmp++; if (second - first !== N + 2 || first < 0 || second < 0)
            begin n_err++; $display("FAIL b2b_period got %0d want %0d", second - first, N + 2); end
        repeat (12) @(negedge clk);
        n_cmp++; if (word_out !== 8'hC3 || seed_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end got w=%h r=%b want c3/1", word_out, seed_ready); end
    endtask

`ifdef PALIN_GEN_SELFCHK_EN
    task automatic test_selfchk;
        logic [7:0] tmp;
        for (int i = 0; i < 200; i++) begin
            send_seed(4'($urandom));
            repeat (10) @(negedge clk);
        end
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clean got %b want 0", chk_err); end
        send_seed(4'b0011);
        tmp = dut.shreg ^ 8'h10;
        force dut.shreg = tmp;
        #1 release dut.shreg;
        repeat (10) @(negedge clk);
        n_cmp++; if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_set got %b want 1", chk_err); end
        repeat (5) @(negedge clk);
        n_cmp++; if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_sticky got %b want 1", chk_err); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_reset got %b want 0", chk_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_seed();
        test_reset_mid();
        test_back_to_back();
`ifdef PALIN_GEN_SELFCHK_EN
        test_selfchk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
